// File: rtl/my_sys_mem_slave.sv
// Avalon-MM style word memory slave: configurable wait states and read latency.
// Define MY_SYS_MEM_SLAVE_STATS_EN to add read/write counters at words DEPTH and DEPTH+1.
module my_sys_mem_slave #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk_clk,
  input  logic        clk_reset_reset_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [29:0] IdxLimit = 30'(DEPTH);

  // Reset asserts asynchronously, releases two edges after the input deasserts
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
    if (!clk_reset_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic          w_req;
  logic          w_accept;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [29:0]   w_idx;
  logic          w_in_range;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_rd_data;
  logic [1:0]    w_unused_addr;
  logic [2:0]    r_wcnt;

  assign w_req             = slave_read | slave_write;
  assign slave_waitrequest = w_req & (r_wcnt != 3'(WAIT_STATES));
  assign w_accept          = w_req & ~slave_waitrequest;
  // Simultaneous read and write is treated as a write only
  assign w_wr_acc          = w_accept & slave_write;
  assign w_rd_acc          = w_accept & slave_read & ~slave_write;
  assign w_idx             = slave_address[31:2];
  assign w_unused_addr     = slave_address[1:0];
  assign w_in_range        = (w_idx < IdxLimit);
  assign w_mem_idx         = w_idx[AW-1:0];

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wcnt <= 3'd0;
    end else if (w_req && slave_waitrequest) begin
      r_wcnt <= r_wcnt + 3'd1;
    end else begin
      r_wcnt <= 3'd0;
    end
  end

  // Memory array is intentionally not reset
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk_clk) begin
    if (w_wr_acc && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_byteenable[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
        end
      end
    end
  end

`ifdef MY_SYS_MEM_SLAVE_STATS_EN
  localparam logic [29:0] IdxRdCnt = 30'(DEPTH);
  localparam logic [29:0] IdxWrCnt = 30'(DEPTH + 1);

  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  // A write addressed to a counter clears it in preference to counting
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd_cnt <= 32'd0;
      r_wr_cnt <= 32'd0;
    end else begin
      if (w_wr_acc && (w_idx == IdxRdCnt)) begin
        r_rd_cnt <= 32'd0;
      end else if (w_rd_acc) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_wr_acc && (w_idx == IdxWrCnt)) begin
        r_wr_cnt <= 32'd0;
      end else if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end
`endif

  always_comb begin
    w_rd_data = 32'hDEAD_BEEF;
    if (w_in_range) begin
      w_rd_data = r_mem[w_mem_idx];
    end
`ifdef MY_SYS_MEM_SLAVE_STATS_EN
    // Read count includes the read being accepted now
    else if (w_idx == IdxRdCnt) begin
      w_rd_data = r_rd_cnt + 32'd1;
    end else if (w_idx == IdxWrCnt) begin
      w_rd_data = r_wr_cnt;
    end
`endif
  end

  // Stage 0 captures at the accept edge; stage READ_LATENCY drives the outputs
  logic [READ_LATENCY:0] r_vld;
  logic [31:0]           r_dat [READ_LATENCY+1];

  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        r_dat[i] <= 32'd0;
      end
    end else begin
      r_vld    <= {r_vld[READ_LATENCY-1:0], w_rd_acc};
      r_dat[0] <= w_rd_acc ? w_rd_data : 32'd0;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign slave_readdatavalid = r_vld[READ_LATENCY];
  assign slave_readdata      = r_dat[READ_LATENCY];

endmodule
